// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with registered read data.
// Grants are combinational; the read-valid flags line up with the RAM's one-cycle latency.
module ram_arbiter #(
  parameter int SIZE_LOG2 = 13,
  parameter int WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [SIZE_LOG2-1:0] a0,
  input  logic [WIDTH-1:0]     wd0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [SIZE_LOG2-1:0] a1,
  input  logic [WIDTH-1:0]     wd1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WIDTH-1:0]     rd0,
  output logic [WIDTH-1:0]     rd1,
  output logic                 ram_we,
  output logic [SIZE_LOG2-1:0] ram_a,
  output logic [WIDTH-1:0]     ram_wd,
  input  logic [WIDTH-1:0]     ram_rd
);

  logic last_q, last_d;
  logic pend0_q, pend0_d;
  logic pend1_q, pend1_d;

  // Under contention the port that did not win last time is served.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    last_d  = last_q;
    if (gnt0) last_d = 1'b0;
    if (gnt1) last_d = 1'b1;
    pend0_d = gnt0 & ~we0;
    pend1_d = gnt1 & ~we1;
  end

  // With no grant the RAM bus idles on port 0's address and data.
  always_comb begin
    ram_we = (gnt0 & we0) | (gnt1 & we1);
    ram_a  = gnt1 ? a1  : a0;
    ram_wd = gnt1 ? wd1 : wd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q  <= 1'b1;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
    end
  end

  assign rvalid0 = pend0_q;
  assign rvalid1 = pend1_q;
  assign rd0     = ram_rd;
  assign rd1     = ram_rd;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter SIZE_LOG2, default 13, RAM address width in words.
REQ-002 SHALL have parameter WIDTH, default 32, data width in bits.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have ports req0/req1, input, 1, requester i asks for one RAM access this cycle.
REQ-006 SHALL have ports we0/we1, input, 1, access type for requester i: 1 = write, 0 = read.
REQ-007 SHALL have ports a0/a1, input, SIZE_LOG2, word address from requester i.
REQ-008 SHALL have ports wd0/wd1, input, WIDTH, write data from requester i.
REQ-009 SHALL have ports gnt0/gnt1, output, 1, access of requester i accepted this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1, output, 1, read data for requester i is valid this cycle.
REQ-011 SHALL have ports rd0/rd1, output, WIDTH, read data to requester i; both equal ram_rd.
REQ-012 SHALL have port ram_we, output, 1, RAM write enable.
REQ-013 SHALL have port ram_a, output, SIZE_LOG2, RAM address.
REQ-014 SHALL have port ram_wd, output, WIDTH, RAM write data.
REQ-015 SHALL have port ram_rd, input, WIDTH, RAM registered read data, valid one cycle after the address is presented.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt0 & gnt1 never both 1.
REQ-017 SHALL compute gnt combinationally in the same cycle as req; a request with req=0 is never granted.
REQ-018 SHALL grant the sole requester when only one of req0/req1 is 1.
REQ-019 SHALL, when req0 and req1 are both 1, grant the port not equal to register last, which is round-robin.
REQ-020 SHALL load last with the granted port index at every posedge where a grant occurs; otherwise last holds.
REQ-021 SHALL drive ram_a, ram_wd and ram_we from the granted port; ram_we = gnt & we of that port.
REQ-022 SHALL, with no grant, drive ram_we=0, ram_a=a0 and ram_wd=wd0.
REQ-023 SHALL register, per port, a pending-read flag set when that port is granted with we=0; rvalid_i equals the flag, so read latency is exactly 1 cycle after gnt.
REQ-024 SHALL clear each pending-read flag on the next posedge unless a new read grant to the same port sets it again, so back-to-back reads give rvalid on consecutive cycles.
REQ-025 SHALL never assert rvalid for a write grant.
REQ-026 SHALL guarantee that a write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the written data in cycle N+2.
REQ-027 SHALL ensure that a requester holding req=1 under continuous contention is granted within 2 cycles, so there is no starvation.
REQ-028 SHALL not buffer requests; an ungranted requester keeps req, we, a and wd stable and retries.

Reset
REQ-029 SHALL, while rst=0, force gnt0=gnt1=0 and ram_we=0 regardless of req.
REQ-030 SHALL, on assertion of rst, asynchronously clear last=1 so port 0 wins the first contention, and clear both pending-read flags so rvalid0=rvalid1=0.
REQ-031 SHALL drop any read in flight when rst is asserted mid-operation; no rvalid follows reset release for a pre-reset grant.
REQ-032 SHALL resume arbitration on the first posedge after rst rises.

Verification
REQ-033 SHALL cover single write: req0=1, we0=1, a0=0x010, wd0=0xDEADBEEF -> gnt0=1, ram_we=1, ram_a=0x010, rvalid0 stays 0.
REQ-034 SHALL cover read after write: write of REQ-033, then next cycle req1=1, we1=0, a1=0x010 -> gnt1=1, and in the following cycle rvalid1=1, rd1=0xDEADBEEF, rvalid0=0.
REQ-035 SHALL cover contention right after reset: req0=req1=1 held for 4 cycles -> grants alternate 0,1,0,1 and gnt is never both 1.
REQ-036 SHALL cover back-to-back reads: port 0 reads 0x001, 0x002, 0x003 on three consecutive cycles, port 1 idle -> rvalid0=1 for 3 consecutive cycles, each returning its address's data in order.
REQ-037 SHALL cover reset mid-read: read granted to port 1, rst=0 asserted before the next posedge -> rvalid1=0 and ram_we=0 during reset, and the first contention after release grants port 0.
REQ-038 SHALL cover idle: req0=req1=0 -> gnt0=gnt1=0, ram_we=0, and last unchanged (verified by a subsequent contention outcome).
